// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM encoding for the
// UART transmitter peripheral. The CPU address decoder imports the same package.
package uart_tx_mmio_pkg;

  // Byte offsets within the peripheral window
  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN = 0;

  // Serial framing: start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Baud counter width able to hold clks-1; at least one bit so that
  // clks == 1 still yields a legal vector.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//
// Handshake: I_push and I_pop are single-cycle strobes sampled on the rising
// edge. A pop is taken only while non-empty. A push is taken while not full,
// or while full if a pop is taken on the same edge (count unchanged). O_dout
// always shows the head entry and is valid whenever O_empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_push,
  input  logic             I_pop,
  input  logic [WIDTH-1:0] I_din,
  output logic [WIDTH-1:0] O_dout,
  output logic             O_full,
  output logic             O_empty,
  output logic [AW:0]      O_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign O_full  = (O_count == (AW+1)'(DEPTH));
  assign O_empty = (O_count == '0);
  assign do_pop  = I_pop & ~O_empty;
  assign do_push = I_push & (~O_full | do_pop);
  assign O_dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      O_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   O_count <= O_count + (AW+1)'(1);
        2'b01:   O_count <= O_count - (AW+1)'(1);
        default: O_count <= O_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr] <= I_din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sticky overflow flag
// and a level interrupt raised when the transmitter has fully drained.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_sel,
  input  logic        I_we,
  input  logic [3:0]  I_addr,
  input  logic [31:0] I_wdata,
  output logic [31:0] O_rdata,
  output logic        O_tx,
  output logic        O_irq
);

  import uart_tx_mmio_pkg::*;

  localparam int             CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam int             AW       = $clog2(FIFO_DEPTH);

  tx_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          tx_bit;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;

  logic          overflow, irq_en, busy;
  logic          bus_wr, push_req, ovf_set, ovf_clr, ctrl_wr;
  logic [31:0]   status_word;
  logic          unused_bits;

  // Upper store bits and the FIFO count are not needed by this block
  assign unused_bits = ^{I_wdata[31:8], fifo_count};

  assign busy      = (state != ST_IDLE);
  assign bus_wr    = I_sel & I_we;
  assign push_req  = bus_wr & (I_addr == OFS_TXDATA);
  assign fifo_push = push_req & (~fifo_full | fifo_pop);
  assign ovf_set   = push_req & fifo_full & ~fifo_pop;
  assign ovf_clr   = bus_wr & (I_addr == OFS_STATUS) & I_wdata[STAT_OVF];
  assign ctrl_wr   = bus_wr & (I_addr == OFS_CTRL);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_push  (fifo_push),
    .I_pop   (fifo_pop),
    .I_din   (I_wdata[7:0]),
    .O_dout  (fifo_dout),
    .O_full  (fifo_full),
    .O_empty (fifo_empty),
    .O_count (fifo_count)
  );

  // Next-state, baud counter, bit index and shift register; pops the FIFO in IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          cnt_next   = CNT_LOAD;
          idx_next   = 3'd0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          cnt_next   = CNT_LOAD;
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          cnt_next = CNT_LOAD;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            idx_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level implied by the current state; registered into O_tx below
  always_comb begin
    tx_bit = 1'b1;
    case (state)
      ST_START: tx_bit = 1'b0;
      ST_DATA:  tx_bit = shift[0];
      default:  tx_bit = 1'b1;
    endcase
  end

  // FSM state register and registered serial output
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      O_tx    <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= idx_next;
      shift   <= shift_next;
      O_tx    <= tx_bit;
    end
  end

  // Sticky overflow, interrupt enable and registered interrupt level
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      O_irq    <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (ctrl_wr) irq_en <= I_wdata[CTRL_IRQ_EN];
      O_irq <= irq_en & fifo_empty & ~busy;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word             = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_OVF]   = overflow;
  end

  // Combinational read mux so single-cycle loads complete in the same cycle
  always_comb begin
    O_rdata = '0;
    if (I_sel) begin
      case (I_addr)
        OFS_STATUS: O_rdata = status_word;
        OFS_CTRL:   O_rdata[CTRL_IRQ_EN] = irq_en;
        default:    O_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a line-level behavioural model (byte queue plus a
// queue of future O_tx levels) checked every cycle, plus directed scenarios
// with literal expectations. A second instance covers CLKS_PER_BIT=1, depth 2.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk, rst;
  logic        sel0, sel1, we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic        tx0, tx1, irq0, irq1;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .I_clk(clk), .I_rst(rst), .I_sel(sel0), .I_we(we), .I_addr(addr),
    .I_wdata(wdata), .O_rdata(rdata0), .O_tx(tx0), .O_irq(irq0)
  );

  uart_tx_mmio #(.CLKS_PER_BIT(1), .FIFO_DEPTH(2)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_sel(sel1), .I_we(we), .I_addr(addr),
    .I_wdata(wdata), .O_rdata(rdata1), .O_tx(tx1), .O_irq(irq1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut ----------------
  logic [7:0] m_q[$];
  logic       m_wave[$];
  int         m_busy_left;
  logic       m_ovf, m_irq_en, m_irq, m_tx;
  logic       m_init = 1'b0;

  task automatic model_step();
    logic       pop_n, irq_n, tx_n;
    logic [7:0] b;
    if (rst) begin
      m_q.delete();
      m_wave.delete();
      m_busy_left = 0;
      m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_tx = 1'b1;
      m_init = 1'b1;
      return;
    end
    pop_n = (m_busy_left == 0) && (m_q.size() != 0);
    irq_n = m_irq_en && (m_q.size() == 0) && (m_busy_left == 0);
    tx_n  = 1'b1;
    if (m_wave.size() != 0) tx_n = m_wave.pop_front();
    if (m_busy_left > 0) m_busy_left--;
    b = 8'h00;
    if (pop_n) b = m_q.pop_front();
    if (sel0 && we) begin
      if (addr == 4'h0) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end else if (addr == 4'h4) begin
        if (wdata[3]) m_ovf = 1'b0;
      end else if (addr == 4'h8) begin
        m_irq_en = wdata[0];
      end
    end
    if (pop_n) begin
      for (int s = 0; s < CPB; s++) m_wave.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int s = 0; s < CPB; s++) m_wave.push_back(b[i]);
      for (int s = 0; s < CPB; s++) m_wave.push_back(1'b1);
      m_busy_left = 10 * CPB;
    end
    m_irq = irq_n;
    m_tx  = tx_n;
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    r = '0;
    if (sel0) begin
      if (addr == 4'h4)
        r = {28'd0, m_ovf, (m_busy_left != 0), (m_q.size() == 0), (m_q.size() == DEPTH)};
      else if (addr == 4'h8)
        r = {31'd0, m_irq_en};
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("tx_model", {31'd0, tx0}, {31'd0, m_tx});
        check("irq_model", {31'd0, irq0}, {31'd0, m_irq});
        check("rdata_model", rdata0, model_read());
      end
    end
  end

  // ---------------- line capture and frame scoreboard ----------------
  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (cap_en) cap_q.push_back(tx0);
    end
  end

  task automatic score_frames(input int cpb, input string name, input int exp_frames);
    int         f, nfr;
    logic [7:0] b;
    f = 1; nfr = 0;
    while (f < cap_q.size()) begin
      if (cap_q[f-1] == 1'b1 && cap_q[f] == 1'b0 && (f + 10*cpb) <= cap_q.size()) begin
        for (int i = 0; i < 8; i++) b[i] = cap_q[f + cpb*(i+1) + cpb/2];
        if (exp_q.size() != 0) check({name, "_byte"}, {24'd0, b}, {24'd0, exp_q.pop_front()});
        nfr++;
        f += 10*cpb;
      end else begin
        f++;
      end
    end
    check({name, "_frames"}, nfr, exp_frames);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic s0, input logic s1, input logic [3:0] a, input logic [31:0] d);
    sel0 = s0; sel1 = s1; we = 1'b1; addr = a; wdata = d;
    tick(1);
    sel0 = 1'b0; sel1 = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input logic s0, input logic s1, input logic [3:0] a,
                            input logic [31:0] exp, input string name);
    sel0 = s0; sel1 = s1; we = 1'b0; addr = a;
    #2;
    check(name, s1 ? rdata1 : rdata0, exp);
    tick(1);
    sel0 = 1'b0; sel1 = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  logic       tx_s[48];
  logic       aux_s[48];
  logic [9:0] frame_55;
  logic       exp_bit;

  initial begin
    frame_55 = 10'b1010101010;  // bit0 start, bits1..8 = 0x55 LSB first, bit9 stop
    rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; we = 1'b0; addr = 4'h0; wdata = '0;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_irq", {31'd0, irq0}, 32'd0);
    check("rst_tx1", {31'd0, tx1}, 32'd1);
    read_check(1'b1, 1'b0, 4'h4, 32'h2, "rst_status");

    // Single frame of 0x55 (upper store bits must be ignored)
    bus_write(1'b1, 1'b0, 4'h0, 32'hFFFF_FF55);
    sel0 = 1'b1; addr = 4'h4;
    for (int k = 0; k < 44; k++) begin
      tx_s[k] = tx0; aux_s[k] = rdata0[2];
      tick(1);
    end
    sel0 = 1'b0;
    for (int k = 0; k < 44; k++) begin
      exp_bit = (k < 2 || k >= 42) ? 1'b1 : frame_55[(k-2)/4];
      check("tx_55", {31'd0, tx_s[k]}, {31'd0, exp_bit});
      check("busy_55", {31'd0, aux_s[k]}, {31'd0, (k >= 1 && k <= 40)});
    end
    tick(4);

    // Ten back-to-back writes: nine frames, last byte dropped
    cap_q.delete();
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      bus_write(1'b1, 1'b0, 4'h0, i);
    end
    read_check(1'b1, 1'b0, 4'h4, 32'hD, "b2b_status_full");
    tick(9*41 + 20);
    cap_en = 1'b0;
    score_frames(CPB, "b2b", 9);
    read_check(1'b1, 1'b0, 4'h4, 32'hA, "ovf_sticky");
    bus_write(1'b1, 1'b0, 4'h4, 32'h0);
    read_check(1'b1, 1'b0, 4'h4, 32'hA, "ovf_keep");
    bus_write(1'b1, 1'b0, 4'h4, 32'h8);
    read_check(1'b1, 1'b0, 4'h4, 32'h2, "ovf_clear");

    // Reset during DATA bit 3 with two bytes queued
    bus_write(1'b1, 1'b0, 4'h0, 32'h00);
    bus_write(1'b1, 1'b0, 4'h0, 32'h22);
    bus_write(1'b1, 1'b0, 4'h0, 32'h33);
    tick(15);
    check("tx_before_rst", {31'd0, tx0}, 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("tx_after_rst", {31'd0, tx0}, 32'd1);
    cap_q.delete();
    cap_en = 1'b1;
    read_check(1'b1, 1'b0, 4'h4, 32'h2, "rst_mid_status");
    tick(100);
    cap_en = 1'b0;
    score_frames(CPB, "post_rst", 0);

    // Interrupt: enable, then one frame of 0xA5
    bus_write(1'b1, 1'b0, 4'h8, 32'h1);
    tick(2);
    check("irq_idle", {31'd0, irq0}, 32'd1);
    read_check(1'b1, 1'b0, 4'h8, 32'h1, "ctrl_read");
    bus_write(1'b1, 1'b0, 4'h0, 32'hA5);
    for (int k = 0; k < 44; k++) begin
      aux_s[k] = irq0;
      tick(1);
    end
    for (int k = 0; k < 44; k++)
      check("irq_frame", {31'd0, aux_s[k]}, {31'd0, (k == 0 || k >= 42)});

    // Unmapped offset, deselected accesses
    read_check(1'b1, 1'b0, 4'hC, 32'h0, "rd_0c");
    read_check(1'b0, 1'b0, 4'h4, 32'h0, "rd_nosel");
    bus_write(1'b1, 1'b0, 4'hC, 32'hFFFF_FFFF);
    bus_write(1'b0, 1'b0, 4'h0, 32'h77);
    bus_write(1'b0, 1'b0, 4'h8, 32'h0);
    read_check(1'b1, 1'b0, 4'h4, 32'h2, "status_unchanged");
    read_check(1'b1, 1'b0, 4'h8, 32'h1, "ctrl_unchanged");
    check("tx_unchanged", {31'd0, tx0}, 32'd1);
    check("irq_unchanged", {31'd0, irq0}, 32'd1);
    tick(2);

    // CLKS_PER_BIT=1, depth-2 instance
    bus_write(1'b0, 1'b1, 4'h0, 32'h55);
    for (int k = 0; k < 14; k++) begin
      tx_s[k] = tx1;
      tick(1);
    end
    for (int k = 0; k < 14; k++) begin
      exp_bit = (k < 2 || k >= 12) ? 1'b1 : frame_55[k-2];
      check("tx_cpb1", {31'd0, tx_s[k]}, {31'd0, exp_bit});
    end
    tick(3);
    for (int i = 1; i <= 4; i++) bus_write(1'b0, 1'b1, 4'h0, i);
    read_check(1'b0, 1'b1, 4'h4, 32'hD, "d2_full_ovf");
    tick(50);
    read_check(1'b0, 1'b1, 4'h4, 32'hA, "d2_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
